instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/mips_pkg.sv | 18 +
 rtl/fetch_pc_reg.sv | 26 ++
 rtl/instr_fetch_ctrl.sv | 106 ++++++++++
 tb/tb_instr_fetch_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, reset PC default, NOP word,
// and the word-alignment helper used wherever an address enters the PC.
package mips_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: holds the word-aligned fetch address, advances by 4 and
// takes branch redirects (redirect wins over advance).
module fetch_pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        CCLK,
  input  logic        RESET,
  input  logic        redirect,
  input  logic        advance,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  // Modulo-2^32 by construction: 32'hFFFF_FFFC + 4 wraps to 0.
  assign pc_plus4 = pc + 32'd4;

  always_ff @(posedge CCLK or posedge RESET) begin
    if (RESET)         pc <= word_align(RESET_PC);
    else if (redirect) pc <= word_align(target);
    else if (advance)  pc <= pc_plus4;
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: drives I-cache requests from the PC, captures
// returned words into the IF/ID outputs, handles stalls, redirects and miss counting.
module instr_fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             CCLK,
  input  logic             RESET,
  input  logic             PCWrite,
  input  logic             BRANCH_TAKEN,
  input  logic [31:0]      BRANCH_TARGET,
  output logic             ICACHE_REQ,
  output logic [31:0]      ICACHE_ADDR,
  input  logic             ICACHE_READY,
  input  logic [31:0]      ICACHE_DATA,
  output logic [31:0]      IF_Instruction,
  output logic [31:0]      IF_PC_4,
  output logic             IF_VALID,
  output logic             IF_Flush,
  output logic             FETCH_STALL,
  output logic [CNT_W-1:0] STALL_CNT
);

  fetch_state_e state, state_nxt;
  logic         redirect, advance, capture;
  logic [31:0]  pc, pc_plus4;

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .CCLK     (CCLK),
    .RESET    (RESET),
    .redirect (redirect),
    .advance  (advance),
    .target   (BRANCH_TARGET),
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  assign ICACHE_REQ  = (state == S_REQ);
  assign ICACHE_ADDR = pc;
  assign FETCH_STALL = (state == S_REQ) && !ICACHE_READY && !BRANCH_TAKEN;

  always_ff @(posedge CCLK or posedge RESET) begin
    if (RESET) state <= S_BOOT;
    else       state <= state_nxt;
  end

  // Redirect outranks a cache hit, which outranks the PCWrite hold/advance decision.
  always_comb begin
    state_nxt = state;
    redirect  = 1'b0;
    advance   = 1'b0;
    capture   = 1'b0;
    case (state)
      S_BOOT: state_nxt = S_REQ;
      S_REQ: begin
        if (BRANCH_TAKEN) begin
          redirect = 1'b1;
        end else if (ICACHE_READY) begin
          capture = 1'b1;
          if (PCWrite) advance   = 1'b1;
          else         state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (BRANCH_TAKEN) begin
          redirect  = 1'b1;
          state_nxt = S_REQ;
        end else if (PCWrite) begin
          advance   = 1'b1;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge CCLK or posedge RESET) begin
    if (RESET) begin
      IF_Instruction <= NOP_WORD;
      IF_PC_4        <= 32'h0;
      IF_VALID       <= 1'b0;
      IF_Flush       <= 1'b0;
    end else begin
      IF_Flush <= redirect;
      if (redirect) begin
        IF_Instruction <= NOP_WORD;
        IF_PC_4        <= 32'h0;
        IF_VALID       <= 1'b0;
      end else if (capture) begin
        IF_Instruction <= ICACHE_DATA;
        IF_PC_4        <= pc_plus4;
        IF_VALID       <= 1'b1;
      end
    end
  end

  always_ff @(posedge CCLK or posedge RESET) begin
    if (RESET)
      STALL_CNT <= '0;
    else if (FETCH_STALL && (STALL_CNT != {CNT_W{1'b1}}))
      STALL_CNT <= STALL_CNT + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: a per-cycle transaction model predicts every
// observable output; the monitor pops predictions at the falling edge and compares.
module tb_instr_fetch_ctrl;

  localparam int          CNT_W = 4;
  localparam logic [31:0] TAG   = 32'hC0DE_0000;

  logic             CCLK = 1'b0;
  logic             RESET = 1'b1;
  logic             PCWrite = 1'b0;
  logic             BRANCH_TAKEN = 1'b0;
  logic [31:0]      BRANCH_TARGET = 32'h0;
  logic             ICACHE_REQ;
  logic [31:0]      ICACHE_ADDR;
  logic             ICACHE_READY = 1'b0;
  logic [31:0]      ICACHE_DATA = 32'h0;
  logic [31:0]      IF_Instruction;
  logic [31:0]      IF_PC_4;
  logic             IF_VALID;
  logic             IF_Flush;
  logic             FETCH_STALL;
  logic [CNT_W-1:0] STALL_CNT;

  instr_fetch_ctrl #(.CNT_W(CNT_W)) dut (
    .CCLK           (CCLK),
    .RESET          (RESET),
    .PCWrite        (PCWrite),
    .BRANCH_TAKEN   (BRANCH_TAKEN),
    .BRANCH_TARGET  (BRANCH_TARGET),
    .ICACHE_REQ     (ICACHE_REQ),
    .ICACHE_ADDR    (ICACHE_ADDR),
    .ICACHE_READY   (ICACHE_READY),
    .ICACHE_DATA    (ICACHE_DATA),
    .IF_Instruction (IF_Instruction),
    .IF_PC_4        (IF_PC_4),
    .IF_VALID       (IF_VALID),
    .IF_Flush       (IF_Flush),
    .FETCH_STALL    (FETCH_STALL),
    .STALL_CNT      (STALL_CNT)
  );

  always #5 CCLK = ~CCLK;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        stall;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        vld;
    logic        flush;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Transaction-level view of the fetch stage.
  logic [31:0] m_pc, m_inst, m_pc4, m_cnt;
  bit          m_booting, m_waiting_accept, m_vld, m_flush;

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_cnt = 32'h0;
    m_booting = 1'b1; m_waiting_accept = 1'b0; m_vld = 1'b0; m_flush = 1'b0;
  endtask

  task automatic model_edge(input bit pcw, input bit br, input logic [31:0] tgt,
                            input bit rdy, input logic [31:0] data);
    if (m_booting) begin
      m_booting = 1'b0;
      m_flush   = 1'b0;
    end else if (br) begin
      m_pc = tgt & 32'hFFFF_FFFC;
      m_inst = 32'h0; m_pc4 = 32'h0; m_vld = 1'b0; m_flush = 1'b1;
      m_waiting_accept = 1'b0;
    end else begin
      m_flush = 1'b0;
      if (m_waiting_accept) begin
        if (pcw) begin
          m_pc = m_pc + 32'd4;
          m_waiting_accept = 1'b0;
        end
      end else if (!rdy) begin
        if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
      end else begin
        m_inst = data; m_pc4 = m_pc + 32'd4; m_vld = 1'b1;
        if (pcw) m_pc = m_pc + 32'd4;
        else     m_waiting_accept = 1'b1;
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit pcw, input bit br, input logic [31:0] tgt,
                       input bit rdy, input logic [31:0] data);
    exp_t e;
    @(posedge CCLK);
    #1;
    RESET = rst; PCWrite = pcw; BRANCH_TAKEN = br; BRANCH_TARGET = tgt;
    ICACHE_READY = rdy; ICACHE_DATA = data;
    if (rst) model_reset();
    e.req   = !m_booting && !m_waiting_accept;
    e.addr  = m_pc;
    e.stall = e.req && !rdy && !br;
    e.inst  = m_inst;
    e.pc4   = m_pc4;
    e.vld   = m_vld;
    e.flush = m_flush;
    e.cnt   = m_cnt;
    exp_q.push_back(e);
    if (!rst) model_edge(pcw, br, tgt, rdy, data);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge CCLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("ICACHE_REQ",     {31'h0, ICACHE_REQ},  {31'h0, e.req});
      chk("ICACHE_ADDR",    ICACHE_ADDR,          e.addr);
      chk("FETCH_STALL",    {31'h0, FETCH_STALL}, {31'h0, e.stall});
      chk("IF_Instruction", IF_Instruction,       e.inst);
      chk("IF_PC_4",        IF_PC_4,              e.pc4);
      chk("IF_VALID",       {31'h0, IF_VALID},    {31'h0, e.vld});
      chk("IF_Flush",       {31'h0, IF_Flush},    {31'h0, e.flush});
      chk("STALL_CNT",      {{(32-CNT_W){1'b0}}, STALL_CNT}, e.cnt);
    end
  end

  initial begin
    model_reset();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);

    // Streaming hits from reset: boot cycle, then 0x0, 0x4, 0x8, 0xC.
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 1, m_pc ^ TAG);

    // Three-cycle miss at 0x10, then the hit.
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 32'hDEAD_BEEF);
    cycle(0, 1, 0, 0, 1, m_pc ^ TAG);
    cycle(0, 1, 0, 0, 0, 0);

    // Capture at 0x20 with downstream stalled, hold two cycles, then resume.
    cycle(0, 1, 1, 32'h20, 0, 0);
    cycle(0, 0, 0, 0, 1, m_pc ^ TAG);
    cycle(0, 0, 0, 0, 1, 32'h1111_1111);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);

    // Redirect to unaligned 0x103 coinciding with a hit.
    cycle(0, 1, 1, 32'h103, 1, 32'hBAD0_BAD0);
    cycle(0, 1, 0, 0, 0, 0);

    // Back-to-back redirects, then wrap past the top of the address space.
    cycle(0, 1, 1, 32'h200, 1, 32'h0);
    cycle(0, 1, 1, 32'hFFFF_FFFE, 0, 32'h0);
    cycle(0, 1, 0, 0, 1, m_pc ^ TAG);
    cycle(0, 1, 0, 0, 0, 0);

    // Reset in the middle of a miss; the late ready lands in the boot cycle.
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 1, 32'h7777_7777);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 1, m_pc ^ TAG);

    for (int i = 0; i < 3000; i++) begin
      bit          rst, pcw, br, rdy;
      logic [31:0] tgt;
      rst = ($urandom_range(0, 199) == 0);
      pcw = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      cycle(rst, pcw, br, tgt, rdy, $urandom);
    end

    @(negedge CCLK);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
